// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side streaming blocks.
package fifo_pkg;
   localparam int unsigned WSIZE_DEF = 16;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } buf_state_t;
endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer (head/tail) carrying a data word plus its burst-last tag.
module fifo_rd_skid
   import fifo_pkg::*;
#(
   parameter int unsigned WSIZE = WSIZE_DEF
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WSIZE-1:0] i_push_data,
   input  logic             i_push_last,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [WSIZE-1:0] o_data,
   output logic             o_last,
   output logic             o_full
);
   buf_state_t       r_state;
   logic [WSIZE-1:0] r_head_data;
   logic [WSIZE-1:0] r_tail_data;
   logic             r_head_last;
   logic             r_tail_last;
   logic             w_pop;

   assign w_pop   = (r_state != EMPTY) && i_ready;
   assign o_valid = (r_state != EMPTY);
   assign o_full  = (r_state == FULL);
   assign o_data  = r_head_data;
   assign o_last  = r_head_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= EMPTY;
         r_head_data <= '0;
         r_tail_data <= '0;
         r_head_last <= 1'b0;
         r_tail_last <= 1'b0;
      end else begin
         case (r_state)
            EMPTY: begin
               if (i_push) begin
                  r_head_data <= i_push_data;
                  r_head_last <= i_push_last;
                  r_state     <= ONE;
               end
            end
            ONE: begin
               case ({i_push, w_pop})
                  2'b11: begin
                     r_head_data <= i_push_data;
                     r_head_last <= i_push_last;
                  end
                  2'b10: begin
                     r_tail_data <= i_push_data;
                     r_tail_last <= i_push_last;
                     r_state     <= FULL;
                  end
                  2'b01:   r_state <= EMPTY;
                  default: ;
               endcase
            end
            FULL: begin
               // Head advances from tail; a concurrent push refills the tail in the same edge.
               if (w_pop) begin
                  r_head_data <= r_tail_data;
                  r_head_last <= r_tail_last;
                  if (i_push) begin
                     r_tail_data <= i_push_data;
                     r_tail_last <= i_push_last;
                  end else begin
                     r_state <= ONE;
                  end
               end
            end
            default: r_state <= EMPTY;
         endcase
      end
   end
endmodule

// File: rtl/fifo_rd_stream.sv
// Converts a show-ahead FIFO read port into a valid/ready stream with burst-last tagging.
// Optional statistics outputs pop_cnt/stall_cnt are enabled by FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int unsigned WSIZE     = WSIZE_DEF,
   parameter int unsigned BURST_LEN = 4
)
(
   input  logic             rclk,
   input  logic             rrst,
   input  logic             rempty,
   input  logic [WSIZE-1:0] rdata,
   output logic             rinc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WSIZE-1:0] out_data,
   output logic             out_last
`ifdef FIFO_RD_STREAM_STATS_EN
   ,
   output logic [31:0]      pop_cnt,
   output logic [31:0]      stall_cnt
`endif
);
   localparam int unsigned    CW       = $clog2(BURST_LEN) + 1;
   localparam logic [CW-1:0]  LAST_IDX = CW'(BURST_LEN - 1);

   logic [CW-1:0] r_burst_cnt;
   logic          w_full;
   logic          w_last;

   assign w_last = (r_burst_cnt == LAST_IDX);
   assign rinc   = !rrst && !rempty && (!w_full || (out_valid && out_ready));

   always_ff @(posedge rclk) begin
      if (rrst) begin
         r_burst_cnt <= '0;
      end else if (rinc) begin
         r_burst_cnt <= w_last ? '0 : r_burst_cnt + 1'b1;
      end
   end

   fifo_rd_skid #(
      .WSIZE (WSIZE)
   ) u_skid (
      .clk         (rclk),
      .rst         (rrst),
      .i_push      (rinc),
      .i_push_data (rdata),
      .i_push_last (w_last),
      .i_ready     (out_ready),
      .o_valid     (out_valid),
      .o_data      (out_data),
      .o_last      (out_last),
      .o_full      (w_full)
   );

`ifdef FIFO_RD_STREAM_STATS_EN
   logic [31:0] r_pop_cnt;
   logic [31:0] r_stall_cnt;

   always_ff @(posedge rclk) begin
      if (rrst) begin
         r_pop_cnt   <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (rinc)                    r_pop_cnt   <= r_pop_cnt + 32'd1;
         if (out_valid && !out_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign pop_cnt   = r_pop_cnt;
   assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: emulated upstream FIFO plus a queue-based model of the output stream.
module tb_fifo_rd_stream;
   localparam int unsigned W  = 16;
   localparam int unsigned BL = 4;

   typedef struct {
      logic [W-1:0] d;
      logic         l;
   } ent_t;

   logic         rclk = 1'b0;
   logic         rrst;
   logic         rempty;
   logic [W-1:0] rdata;
   logic         rinc;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_last;
`ifdef FIFO_RD_STREAM_STATS_EN
   logic [31:0]  pop_cnt;
   logic [31:0]  stall_cnt;
`endif

   fifo_rd_stream #(
      .WSIZE     (W),
      .BURST_LEN (BL)
   ) dut (
      .rclk      (rclk),
      .rrst      (rrst),
      .rempty    (rempty),
      .rdata     (rdata),
      .rinc      (rinc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
`ifdef FIFO_RD_STREAM_STATS_EN
      ,
      .pop_cnt   (pop_cnt),
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 rclk = ~rclk;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] src[$];   // upstream FIFO contents
   ent_t         mq[$];    // words expected in the output buffer, head first
   int           burst_idx = 0;
   int           m_pop = 0, m_stall = 0;
   int           n_rinc, n_valid, n_acc, n_acc_last;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle, entered and left at the falling edge.
   task automatic step(input logic ready, input logic rst);
      logic exp_rinc;
      logic exp_valid;
      rrst      = rst;
      out_ready = ready;
      rempty    = (src.size() == 0);
      rdata     = rempty ? W'($urandom) : src[0];
      #1;
      exp_valid = (mq.size() != 0);
      exp_rinc  = !rst && !rempty && (mq.size() < 2 || (exp_valid && ready));
      chk("rinc", 32'(rinc), 32'(exp_rinc));
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid) begin
         chk("out_data", 32'(out_data), 32'(mq[0].d));
         chk("out_last", 32'(out_last), 32'(mq[0].l));
      end
`ifdef FIFO_RD_STREAM_STATS_EN
      chk("pop_cnt", pop_cnt, 32'(m_pop));
      chk("stall_cnt", stall_cnt, 32'(m_stall));
`endif
      if (exp_rinc) n_rinc++;
      if (exp_valid) n_valid++;
      if (exp_valid && ready) begin
         n_acc++;
         if (mq[0].l) n_acc_last++;
      end
      @(posedge rclk);
      if (rst) begin
         mq.delete();
         burst_idx = 0;
         m_pop     = 0;
         m_stall   = 0;
         #1;
         chk("rst_out_data", 32'(out_data), 32'd0);
         chk("rst_out_last", 32'(out_last), 32'd0);
      end else begin
         if (exp_valid && !ready) m_stall++;
         if (exp_valid && ready) void'(mq.pop_front());
         if (exp_rinc) begin
            ent_t e;
            e.d = src.pop_front();
            e.l = ((burst_idx % BL) == BL - 1);
            burst_idx++;
            m_pop++;
            mq.push_back(e);
         end
      end
      @(negedge rclk);
   endtask

   task automatic clr_stats();
      n_rinc = 0; n_valid = 0; n_acc = 0; n_acc_last = 0;
   endtask

   initial begin
      logic [W-1:0] w1;
      rrst = 1'b1; rempty = 1'b1; rdata = '0; out_ready = 1'b0;
      @(posedge rclk);
      @(negedge rclk);

      // Reset held 3 cycles with data available upstream
      for (int i = 1; i <= 8; i++) src.push_back(W'(i));
      clr_stats();
      repeat (3) step(1'b1, 1'b1);
      chk("reset_rinc_count", 32'(n_rinc), 32'd0);

      // Continuous flow 0x0001..0x0008
      clr_stats();
      repeat (11) step(1'b1, 1'b0);
      chk("flow_words", 32'(n_acc), 32'd8);
      chk("flow_lasts", 32'(n_acc_last), 32'd2);

      // Backpressure with 6 words available
      for (int i = 0; i < 6; i++) src.push_back(W'($urandom));
      w1 = src[0];
      clr_stats();
      repeat (5) step(1'b0, 1'b0);
      chk("bp_pops", 32'(n_rinc), 32'd2);
      chk("bp_head_held", 32'(out_data), 32'(w1));
      clr_stats();
      repeat (10) step(1'b1, 1'b0);
      chk("bp_drained", 32'(n_acc), 32'd6);

      // Single word then empty
      src.push_back(16'hBEEF);
      clr_stats();
      repeat (5) step(1'b1, 1'b0);
      chk("empty_pulses", 32'(n_rinc), 32'd1);
      chk("empty_beats", 32'(n_valid), 32'd1);
      chk("empty_valid_low", 32'(out_valid), 32'd0);

      // Reset after 2 of 4 words of a burst
      step(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) src.push_back(W'($urandom));
      repeat (2) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      chk("midrst_valid", 32'(out_valid), 32'd0);
      for (int i = 0; i < 4; i++) src.push_back(W'($urandom));
      clr_stats();
      repeat (10) step(1'b1, 1'b0);
      chk("midrst_words", 32'(n_acc), 32'd6);
      chk("midrst_lasts", 32'(n_acc_last), 32'd1);

`ifdef FIFO_RD_STREAM_STATS_EN
      // 8 pops with 3 stall cycles
      step(1'b1, 1'b1);
      for (int i = 0; i < 8; i++) src.push_back(W'($urandom));
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      repeat (8) step(1'b1, 1'b0);
      chk("stats_pop_cnt", pop_cnt, 32'd8);
      chk("stats_stall_cnt", stall_cnt, 32'd3);
`endif

      // Random traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 1) == 1) src.push_back(W'($urandom));
         step($urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0);
      end
      src.delete();
      repeat (5) step(1'b1, 1'b0);
      chk("final_empty", 32'(out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter WSIZE, default 16: data word width in bits, equal to the upstream FIFO WSIZE.
REQ-002 Parameter BURST_LEN, default 4: words per burst; out_last marks the final word; legal range 1..256.
REQ-003 rclk  input  1  read-domain clock; the single clock of the block.
REQ-004 rrst  input  1  synchronous, active-high reset, sampled on rising rclk.
REQ-005 rempty  input  1  FIFO empty flag, synchronous to rclk.
REQ-006 rdata  input  WSIZE  FIFO show-ahead read data, valid whenever rempty=0.
REQ-007 rinc  output  1  FIFO pop strobe; each rclk edge with rinc=1 consumes one word.
REQ-008 out_valid  output  1  out_data/out_last hold a valid word.
REQ-009 out_ready  input  1  downstream accepts the word on an edge with out_valid=1.
REQ-010 out_data  output  WSIZE  head word of the output buffer.
REQ-011 out_last  output  1  head word is the final word of a BURST_LEN burst.

Function
REQ-012 The block SHALL contain a 2-entry output buffer with states EMPTY (0 words), ONE (1 word) and FULL (2 words).
REQ-013 rinc SHALL equal !rempty && (state!=FULL || (out_valid && out_ready)); it is combinational and has no dependence on rinc itself.
REQ-014 On an edge with rinc=1, rdata SHALL be written into the buffer tail; the word SHALL reach out_data on the next cycle (1-cycle latency) when the buffer was EMPTY.
REQ-015 Transitions: push only -> count+1; pop only (out_valid && out_ready) -> count-1; push and pop together -> count unchanged, order preserved.
REQ-016 In FULL with a simultaneous push and pop, the head SHALL advance and the new word SHALL enter the tail in the same edge, with no bubble and no loss.
REQ-017 out_valid SHALL be 1 exactly when state!=EMPTY; out_data and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-018 A burst counter of width $clog2(BURST_LEN)+1 bits SHALL count pushed words.
  - Each pushed word is tagged last when counter==BURST_LEN-1.
  - The counter then wraps to 0.
  - With BURST_LEN=1 every word is tagged last.
REQ-019 The last tag SHALL be stored with the word in the buffer and presented as out_last.
REQ-020 With rempty=1, rinc SHALL be 0 regardless of buffer state; no word is fabricated.

Reset
REQ-021 While rrst=1: state=EMPTY, out_valid=0, out_last=0, out_data=0, burst counter=0.
REQ-022 While rrst=1, rinc SHALL be 0.
REQ-023 A reset asserted mid-burst SHALL discard the buffered words and restart burst numbering at 0.

Configuration
REQ-024 With macro FIFO_RD_STREAM_STATS_EN defined, the block SHALL add two outputs:
  - pop_cnt (32 bits): increments on each rinc edge.
  - stall_cnt (32 bits): increments on each edge with out_valid=1 and out_ready=0.
  - Both counters wrap modulo 2^32 and reset to 0.
REQ-025 Without FIFO_RD_STREAM_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-026 The shared package fifo_pkg SHALL hold the default WSIZE localparam and the buffer-state enum {EMPTY, ONE, FULL}.
REQ-027 The 2-entry buffer SHALL be a sub-module fifo_rd_skid; burst counting, rinc generation and statistics SHALL remain in fifo_rd_stream.

Verification
REQ-028 Reset check: rrst=1 for 3 cycles with rempty=0 -> rinc=0 and out_valid=0 throughout.
REQ-029 Continuous flow: FIFO preloaded with 0x0001..0x0008, out_ready=1 -> out_data 0x0001..0x0008 on consecutive cycles, out_last on 0x0004 and 0x0008.
REQ-030 Backpressure: out_ready=0 for 5 cycles with 6 words available -> exactly 2 pops, then rinc=0, out_data held at word 1; after out_ready=1, all 6 words arrive in order.
REQ-031 Empty boundary: single word 0xBEEF, then rempty=1 -> one rinc pulse, one out_valid beat, then out_valid=0.
REQ-032 Reset mid-burst: rrst pulsed after 2 of 4 words -> buffer empty; the next popped word starts a new burst, with out_last on its 4th word.
REQ-033 Stats (FIFO_RD_STREAM_STATS_EN defined): 8 pops with 3 stall cycles -> pop_cnt=8, stall_cnt=3.
